spi_eeprom_reader: RTL
======================

Name: spi_eeprom_reader

Overview:
SPI mode-0 master that issues a READ (0x03) sequential read to the 25AA512 serial EEPROM and streams the returned bytes out on a valid/ready byte interface. It is the block directly upstream of the hello datapath: hello requests a start address and byte count, and consumes bytes. The block owns all six flash pins, so no other logic drives the EEPROM.

Parameters:
CLK_DIV, 1, clk cycles per SCK half-period (>=1); SCK frequency = f_clk / (2*CLK_DIV)
CSS_CYCLES, 1, clk cycles CS_N is held low before the first SCK rising edge (tCSS)
CSH_CYCLES, 1, clk cycles after the last SCK falling edge before CS_N rises (tCSH)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
start  in  1  one-cycle request; accepted only when busy=0
addr  in  16  first EEPROM byte address, captured on accepted start
len  in  16  number of bytes to read, captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the transaction completes
data  out  8  received byte, MSB first on the wire
data_valid  out  1  data holds a byte not yet consumed
data_ready  in  1  consumer accepts data when data_valid & data_ready
flash_si  out  1  MOSI to EEPROM SI
flash_so  in  1  MISO from EEPROM SO
flash_sck  out  1  SPI clock, idles low
flash_cs_n  out  1  chip select, active low
flash_wp_n  out  1  tied 1
flash_hold_n  out  1  tied 1

Behaviour:
- Reset (rst_n=0 at a rising clk edge) forces: flash_cs_n=1, flash_sck=0, flash_si=0, busy=0, done=0, data_valid=0, data=0, FSM=IDLE. This applies mid-transaction: CS_N rises on that edge, any partial byte is discarded, and no done pulse is produced.
- FSM states: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA -> CS_HOLD -> FIN -> IDLE.
- IDLE: on start with len!=0, capture addr and len, set busy, drop CS_N, and enter CS_SETUP. On start with len==0, pulse done the next cycle; CS_N is never asserted and busy stays 0.
- CS_SETUP: wait CSS_CYCLES, then enter CMD.
- Bit timing: SI is updated while SCK is low. SCK is high for CLK_DIV cycles, then low for CLK_DIV cycles. SO is sampled on the clk edge that raises SCK. One bit therefore takes 2*CLK_DIV cycles, and one byte takes 16*CLK_DIV cycles.
- CMD: shift out 8'h03, MSB first. ADDR: shift out the 16-bit address, MSB first.
- DATA: shift in 8 bits per byte. After the 8th sample and the following SCK falling edge, the byte is moved to data and data_valid=1. A remaining-byte counter is decremented per byte.
- Buffering: one output register plus the shifter. The next byte may be shifted in while data_valid=1. If the shifter completes while data_valid is still 1, SCK holds low (stall) until the byte is consumed. The transfer then resumes with no lost or duplicated byte. CS_N stays low during a stall.
- data_valid clears on the edge where data_valid & data_ready, unless a new byte loads on the same edge, in which case it stays 1 with the new data.
- After the last byte loads into data: CS_HOLD waits CSH_CYCLES, then CS_N rises. FIN waits until data_valid=0 (last byte consumed), then pulses done, clears busy, and returns to IDLE.
- Address wrap: the EEPROM auto-increments and wraps from 0xFFFF to 0x0000. The block applies no special handling; len up to 65535 is legal.
- start while busy=1 is ignored.
- flash_si=0 whenever not in CMD/ADDR.
- flash_wp_n=1 and flash_hold_n=1 at all times, including during reset.

Decomposition:
- Shared package/header: SPI opcode constants (READ=8'h03, RDSR=8'h05, WREN=8'h06, WRITE=8'h02) and FSM state encoding localparams, for reuse by a future writer block.
- One sub-module: spi_shift_byte. It provides the CLK_DIV-timed SCK generation and an 8-bit MSB-first shift in/out, with a stall input and a byte-complete strobe. The top-level FSM sequences command, address and data bytes through it.

Test Plan:
- Setup for scenarios 1-4: EEPROM model preloaded with DE AD BE EF at 0x0000..0x0003; CLK_DIV=1.
- 1. start addr=0x0000 len=4, data_ready=1 -> bytes DE,AD,BE,EF; exactly 8+16+32 SCK rising edges under one CS_N low; done pulses once; busy falls the same cycle.
- 2. addr=0x0002 len=2, data_ready held 0 for 40 cycles, then 1 -> SCK stalls low after the 2nd byte shifts in; output BE,EF in order, no duplicates.
- 3. len=0 -> done pulse one cycle after start, flash_cs_n never 0, no SCK edges.
- 4. rst_n=0 during ADDR of a len=4 read -> next edge flash_cs_n=1, sck=0, data_valid=0, no done; a fresh start addr=0x0001 len=1 returns AD.
- 5. Preload 0xFFFF=0x5A, start addr=0xFFFF len=2 -> 5A then DE (wrap to 0x0000).
- 6. CLK_DIV=3 rerun of scenario 1 -> same data; SCK high and low phases each measure exactly 3 clk cycles.

Source files
------------

// File: rtl/spi_eeprom_reader_pkg.sv
// Shared SPI EEPROM definitions: opcodes and FSM state encoding, reused by reader/writer blocks.
package spi_eeprom_reader_pkg;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_RDSR  = 8'h05;
  localparam logic [7:0] SPI_OP_WREN  = 8'h06;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_CMD      = 3'd2,
    S_ADDR     = 3'd3,
    S_DATA     = 3'd4,
    S_CS_HOLD  = 3'd5,
    S_FIN      = 3'd6
  } spi_state_e;

endpackage

// File: rtl/spi_shift_byte.sv
// SPI mode-0 bit engine: CLK_DIV-timed SCK, 8-bit MSB-first shift out/in.
// byte_done marks the cycle whose edge drops SCK after the 8th sample; the
// caller answers on that edge with load (continue with tx_byte) or not (stop).
module spi_shift_byte #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       stall,
  input  logic       so,
  output logic       sck,
  output logic       si,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic        sck_q;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        phase_end;
  logic        rise;
  logic        fall;

  assign phase_end = (div_cnt == DIV_LAST);
  // Stall only holds the low phase, so a finished byte never gets clocked over.
  assign rise      = active & ~sck_q & phase_end & ~stall;
  assign fall      = active & sck_q & phase_end;
  assign byte_done = fall & (bit_cnt == 3'd7);

  // Control: SCK phase timing and bit counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      sck_q   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (!active) begin
      if (load) begin
        active  <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (rise || fall) begin
      div_cnt <= '0;
      sck_q   <= ~sck_q;
      if (fall) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done && !load) active <= 1'b0;
      end
    end else if (!phase_end) begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Data: SI changes on the falling edge, SO is captured on the rising edge
  always_ff @(posedge clk) begin
    if ((!active && load) || byte_done) tx_sr <= tx_byte;
    else if (fall)                      tx_sr <= {tx_sr[6:0], 1'b0};
    if (rise) rx_sr <= {rx_sr[6:0], so};
  end

  assign sck     = sck_q;
  assign si      = tx_sr[7];
  assign rx_byte = rx_sr;

endmodule

// File: rtl/spi_eeprom_reader.sv
// 25AA512 sequential-read master: READ opcode, 16-bit address, then streams
// len bytes out through a one-register valid/ready buffer with SCK stall.
module spi_eeprom_reader
  import spi_eeprom_reader_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int CSS_CYCLES = 1,
  parameter int CSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        flash_si,
  input  logic        flash_so,
  output logic        flash_sck,
  output logic        flash_cs_n,
  output logic        flash_wp_n,
  output logic        flash_hold_n
);

  spi_state_e  state, state_nxt;
  logic [15:0] addr_q;
  logic [15:0] rem;
  logic [15:0] wait_cnt;
  logic        addr_lo;
  logic        pending;
  logic        sh_load;
  logic [7:0]  sh_tx;
  logic        sh_sck;
  logic        sh_si;
  logic [7:0]  sh_rx;
  logic        sh_done;
  logic        wait_done;
  logic        space;
  logic        move;
  logic        last_byte;
  logic        done_set;
  logic        cs_n_c;
  logic        si_en;
  logic        accept;

  assign accept    = (state == S_IDLE) && start && (len != 16'd0);
  assign wait_done = (state == S_CS_SETUP) ? (wait_cnt == 16'(CSS_CYCLES - 1))
                                           : (wait_cnt == 16'(CSH_CYCLES - 1));
  assign space     = ~data_valid | data_ready;
  // A completed byte (fresh or parked) moves into data once the register frees up.
  assign move      = (state == S_DATA) && (sh_done || pending) && space;
  assign last_byte = (rem == 16'd1);

  spi_shift_byte #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .tx_byte   (sh_tx),
    .stall     (pending),
    .so        (flash_so),
    .sck       (sh_sck),
    .si        (sh_si),
    .rx_byte   (sh_rx),
    .byte_done (sh_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept)                state_nxt = S_CS_SETUP;
      S_CS_SETUP: if (wait_done)             state_nxt = S_CMD;
      S_CMD:      if (sh_done)               state_nxt = S_ADDR;
      S_ADDR:     if (sh_done && addr_lo)    state_nxt = S_DATA;
      S_DATA:     if (move && last_byte)     state_nxt = S_CS_HOLD;
      S_CS_HOLD:  if (wait_done)             state_nxt = S_FIN;
      S_FIN:      if (!data_valid)           state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // Output decode: chip select, shifter byte feed, done request
  always_comb begin
    cs_n_c   = 1'b1;
    si_en    = 1'b0;
    sh_load  = 1'b0;
    sh_tx    = 8'h00;
    done_set = 1'b0;
    case (state)
      S_IDLE:     done_set = start && (len == 16'd0);
      S_CS_SETUP: begin cs_n_c = 1'b0; sh_load = wait_done; sh_tx = SPI_OP_READ; end
      S_CMD:      begin cs_n_c = 1'b0; si_en = 1'b1; sh_load = 1'b1; sh_tx = addr_q[15:8]; end
      S_ADDR:     begin
        cs_n_c  = 1'b0;
        si_en   = 1'b1;
        sh_load = 1'b1;
        sh_tx   = addr_lo ? 8'h00 : addr_q[7:0];
      end
      S_DATA:     begin cs_n_c = 1'b0; sh_load = ~last_byte; end
      S_CS_HOLD:  cs_n_c = 1'b0;
      S_FIN:      done_set = ~data_valid;
      default:    cs_n_c = 1'b1;
    endcase
  end

  // Control registers: wait timer, address byte select, output buffer handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done       <= 1'b0;
      wait_cnt   <= '0;
      addr_lo    <= 1'b0;
      pending    <= 1'b0;
      data_valid <= 1'b0;
      data       <= 8'h00;
    end else begin
      done     <= done_set;
      wait_cnt <= (state_nxt != state) ? 16'd0 : wait_cnt + 16'd1;
      addr_lo  <= (state == S_ADDR) ? (addr_lo | sh_done) : 1'b0;
      if (move)                              pending <= 1'b0;
      else if ((state == S_DATA) && sh_done) pending <= 1'b1;
      if (move) begin
        data       <= sh_rx;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  // Transaction parameters captured on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
      rem    <= len;
    end else if (move) begin
      rem <= rem - 16'd1;
    end
  end

  assign busy         = (state != S_IDLE);
  assign flash_cs_n   = cs_n_c;
  assign flash_sck    = sh_sck;
  assign flash_si     = si_en & sh_si;
  assign flash_wp_n   = 1'b1;
  assign flash_hold_n = 1'b1;

endmodule
